// File: rtl/matrix_op_dispatch.sv
// Command dispatcher for the matrix engines: validates a command, starts one engine
// with a level start/done handshake and grants it the shared BRAM port until release.
module matrix_op_dispatch #(
  parameter int unsigned NUM_OPS        = 4,
  parameter int unsigned ELEMENT_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned MAX_DIM        = 5,
  parameter int unsigned TIMEOUT_CYCLES = 4000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [1:0]                         cmd_op,
  input  logic [3:0]                         cmd_m,
  input  logic [3:0]                         cmd_n,
  input  logic [ADDR_WIDTH-1:0]              cmd_addr1,
  input  logic [ADDR_WIDTH-1:0]              cmd_addr2,
  input  logic [ADDR_WIDTH-1:0]              cmd_addr_res,
  output logic                               rsp_valid,
  output logic [1:0]                         rsp_status,
  output logic [15:0]                        rsp_cycles,
  output logic                               busy,
  output logic [NUM_OPS-1:0]                 eng_start,
  input  logic [NUM_OPS-1:0]                 eng_done,
  output logic [3:0]                         eng_dim_m,
  output logic [3:0]                         eng_dim_n,
  output logic [ADDR_WIDTH-1:0]              eng_addr_op1,
  output logic [ADDR_WIDTH-1:0]              eng_addr_op2,
  output logic [ADDR_WIDTH-1:0]              eng_addr_res,
  input  logic [NUM_OPS-1:0]                 eng_rd_en,
  input  logic [NUM_OPS-1:0]                 eng_wr_en,
  input  logic [NUM_OPS*ADDR_WIDTH-1:0]      eng_rd_addr,
  input  logic [NUM_OPS*ADDR_WIDTH-1:0]      eng_wr_addr,
  input  logic [NUM_OPS*ELEMENT_WIDTH-1:0]   eng_wr_data,
  output logic [ELEMENT_WIDTH-1:0]           eng_rd_data,
  output logic                               bram_rd_en,
  output logic                               bram_wr_en,
  output logic [ADDR_WIDTH-1:0]              bram_rd_addr,
  output logic [ADDR_WIDTH-1:0]              bram_wr_addr,
  output logic [ELEMENT_WIDTH-1:0]           bram_wr_data,
  input  logic [ELEMENT_WIDTH-1:0]           bram_rd_data
);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, RELEASE, RESP} state_t;

  state_t      state, next_state;
  logic [1:0]  grant;
  logic [31:0] run_cnt, cnt_nxt;
  logic [1:0]  rel_cnt;
  logic [1:0]  status_q, status_nxt;
  logic        accept, op_bad, dim_bad, sel_done, timed_out;

  assign accept    = cmd_valid && cmd_ready;
  assign op_bad    = 32'(cmd_op) >= NUM_OPS;
  assign dim_bad   = (cmd_m == '0) || (32'(cmd_m) > MAX_DIM) ||
                     (cmd_n == '0) || (32'(cmd_n) > MAX_DIM);
  assign timed_out = (run_cnt + 32'd1) >= TIMEOUT_CYCLES;
  assign eng_rd_data = bram_rd_data;

  always_comb begin
    sel_done = 1'b0;
    for (int unsigned k = 0; k < NUM_OPS; k++)
      if (grant == 2'(k)) sel_done = eng_done[k];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = (op_bad || dim_bad) ? RESP : LAUNCH;
      LAUNCH:  next_state = RUN;
      RUN:     if (sel_done || timed_out) next_state = RELEASE;
      RELEASE: if (!sel_done || rel_cnt == 2'd3) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status and run length are resolved here so the response registers can load
  // them on the same edge that enters RESP.
  always_comb begin
    status_nxt = status_q;
    cnt_nxt    = run_cnt;
    unique case (state)
      IDLE: if (accept) begin
        status_nxt = op_bad ? 2'd1 : (dim_bad ? 2'd2 : 2'd0);
        cnt_nxt    = '0;
      end
      LAUNCH: cnt_nxt = '0;
      RUN: begin
        cnt_nxt = run_cnt + 32'd1;
        if (sel_done)       status_nxt = 2'd0;
        else if (timed_out) status_nxt = 2'd3;
      end
      RELEASE: if (sel_done && rel_cnt == 2'd3) status_nxt = 2'd3;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_status   <= '0;
      rsp_cycles   <= '0;
      eng_start    <= '0;
      eng_dim_m    <= '0;
      eng_dim_n    <= '0;
      eng_addr_op1 <= '0;
      eng_addr_op2 <= '0;
      eng_addr_res <= '0;
      grant        <= '0;
      run_cnt      <= '0;
      rel_cnt      <= '0;
      status_q     <= '0;
    end else begin
      cmd_ready <= (next_state == IDLE);
      busy      <= (next_state != IDLE);
      rsp_valid <= (next_state == RESP);
      status_q  <= status_nxt;
      run_cnt   <= cnt_nxt;
      if (next_state == RESP && state != RESP) begin
        rsp_status <= status_nxt;
        rsp_cycles <= (cnt_nxt > 32'h0000_FFFF) ? 16'hFFFF : cnt_nxt[15:0];
      end
      unique case (state)
        IDLE: if (accept) begin
          eng_dim_m    <= cmd_m;
          eng_dim_n    <= cmd_n;
          eng_addr_op1 <= cmd_addr1;
          eng_addr_op2 <= cmd_addr2;
          eng_addr_res <= cmd_addr_res;
          if (!op_bad && !dim_bad) grant <= cmd_op;
        end
        LAUNCH: eng_start <= NUM_OPS'(1) << grant;
        RUN: begin
          rel_cnt <= '0;
          if (sel_done || timed_out) eng_start <= '0;
        end
        RELEASE: rel_cnt <= rel_cnt + 2'd1;
        RESP:    grant   <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    bram_rd_en   = 1'b0;
    bram_wr_en   = 1'b0;
    bram_rd_addr = '0;
    bram_wr_addr = '0;
    bram_wr_data = '0;
    if (state == LAUNCH || state == RUN || state == RELEASE) begin
      for (int unsigned k = 0; k < NUM_OPS; k++) begin
        if (grant == 2'(k)) begin
          bram_rd_en   = eng_rd_en[k];
          bram_wr_en   = eng_wr_en[k];
          bram_rd_addr = eng_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
          bram_wr_addr = eng_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
          bram_wr_data = eng_wr_data[k*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_op_dispatch.sv
// Bench for matrix_op_dispatch: model engines, random BRAM requests and a
// transaction-level timeline model derived from the command/response rules.
module tb_matrix_op_dispatch;

  localparam int NOPS = 3;
  localparam int AW   = 10;
  localparam int EW   = 8;
  localparam int MAXD = 5;
  localparam int TMO  = 400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [3:0]        cmd_m, cmd_n;
  logic [AW-1:0]     cmd_addr1, cmd_addr2, cmd_addr_res;
  logic              rsp_valid;
  logic [1:0]        rsp_status;
  logic [15:0]       rsp_cycles;
  logic              busy;
  logic [NOPS-1:0]   eng_start;
  logic [NOPS-1:0]   eng_done = '0;
  logic [3:0]        eng_dim_m, eng_dim_n;
  logic [AW-1:0]     eng_addr_op1, eng_addr_op2, eng_addr_res;
  logic [NOPS-1:0]   eng_rd_en, eng_wr_en;
  logic [NOPS*AW-1:0] eng_rd_addr, eng_wr_addr;
  logic [NOPS*EW-1:0] eng_wr_data;
  logic [EW-1:0]     eng_rd_data, bram_wr_data, bram_rd_data;
  logic              bram_rd_en, bram_wr_en;
  logic [AW-1:0]     bram_rd_addr, bram_wr_addr;

  matrix_op_dispatch #(
    .NUM_OPS(NOPS), .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW),
    .MAX_DIM(MAXD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_m(cmd_m), .cmd_n(cmd_n),
    .cmd_addr1(cmd_addr1), .cmd_addr2(cmd_addr2), .cmd_addr_res(cmd_addr_res),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_cycles(rsp_cycles),
    .busy(busy), .eng_start(eng_start), .eng_done(eng_done),
    .eng_dim_m(eng_dim_m), .eng_dim_n(eng_dim_n),
    .eng_addr_op1(eng_addr_op1), .eng_addr_op2(eng_addr_op2), .eng_addr_res(eng_addr_res),
    .eng_rd_en(eng_rd_en), .eng_wr_en(eng_wr_en),
    .eng_rd_addr(eng_rd_addr), .eng_wr_addr(eng_wr_addr), .eng_wr_data(eng_wr_data),
    .eng_rd_data(eng_rd_data),
    .bram_rd_en(bram_rd_en), .bram_wr_en(bram_wr_en),
    .bram_rd_addr(bram_rd_addr), .bram_wr_addr(bram_wr_addr),
    .bram_wr_data(bram_wr_data), .bram_rd_data(bram_rd_data)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit iso_mode = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Engine model: done rises after eng_dly cycles of start (0 = never);
  // a stuck engine keeps done high after start drops.
  int eng_dly   [NOPS];
  bit eng_stuck [NOPS];
  int eng_cnt   [NOPS];
  always @(posedge clk) begin
    for (int k = 0; k < NOPS; k++) begin
      if (eng_start[k]) begin
        eng_cnt[k]  <= eng_cnt[k] + 1;
        eng_done[k] <= (eng_dly[k] != 0) && (eng_cnt[k] + 1 >= eng_dly[k]);
      end else begin
        eng_cnt[k]  <= 0;
        eng_done[k] <= eng_stuck[k] & eng_done[k];
      end
    end
  end

  task automatic drive_reqs();
    for (int k = 0; k < NOPS; k++) begin
      eng_rd_en[k] = 1'($urandom);
      eng_wr_en[k] = 1'($urandom);
      eng_rd_addr[k*AW +: AW] = AW'($urandom);
      eng_wr_addr[k*AW +: AW] = AW'($urandom);
      eng_wr_data[k*EW +: EW] = EW'($urandom);
    end
    if (iso_mode) begin
      eng_rd_en[2] = 1'b1;
      eng_rd_addr[2*AW +: AW] = 10'h055;
      if (eng_rd_addr[AW +: AW] == 10'h055) eng_rd_addr[AW +: AW] = 10'h056;
    end
    bram_rd_data = EW'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1 drive_reqs();
    #1;
  endtask

  task automatic check_mux(input int g);
    logic [63:0] got_v, exp_v;
    got_v = {26'b0, bram_rd_en, bram_wr_en, bram_rd_addr, bram_wr_addr, bram_wr_data, eng_rd_data};
    if (g < 0)
      exp_v = {26'b0, 2'b00, {AW{1'b0}}, {AW{1'b0}}, {EW{1'b0}}, bram_rd_data};
    else
      exp_v = {26'b0, eng_rd_en[g], eng_wr_en[g], eng_rd_addr[g*AW +: AW],
               eng_wr_addr[g*AW +: AW], eng_wr_data[g*EW +: EW], bram_rd_data};
    check("bram_mux", got_v, exp_v);
  endtask

  // Offsets after the accept edge: 0 LAUNCH, 1..R RUN, then release cycles, then RESP.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] m, input logic [3:0] n,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [AW-1:0] ar, input int dly, input bit stuck);
    int exp_st, r_len, rel, lat, g;
    check("cmd_ready_idle", cmd_ready, 1);
    if (int'(op) < NOPS) begin
      eng_dly[op]   = dly;
      eng_stuck[op] = stuck;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_m = m; cmd_n = n;
    cmd_addr1 = a1; cmd_addr2 = a2; cmd_addr_res = ar;
    rel = 0;
    if (int'(op) >= NOPS) exp_st = 1;
    else if (m == 0 || m > MAXD || n == 0 || n > MAXD) exp_st = 2;
    else if (dly == 0 || dly + 1 > TMO) begin exp_st = 3; r_len = TMO; rel = 1; end
    else begin exp_st = stuck ? 3 : 0; r_len = dly + 1; rel = stuck ? 4 : 2; end
    if (exp_st == 1 || exp_st == 2) begin r_len = 0; lat = 0; end
    else lat = r_len + rel + 1;
    tick();
    cmd_valid = 1'b0;
    for (int o = 0; o <= lat + 1; o++) begin
      if (o > 0) tick();
      g = (lat > 0 && o < lat) ? int'(op) : -1;
      check_mux(g);
      check("rsp_valid", rsp_valid, o == lat);
      check("eng_start", eng_start, (o >= 1 && o <= r_len) ? (64'd1 << op) : 64'd0);
      if (o == 0) begin
        check("cmd_ready_drop", cmd_ready, 0);
        check("latched_dims", {eng_dim_m, eng_dim_n}, {m, n});
        check("latched_addrs", {eng_addr_op1, eng_addr_op2, eng_addr_res}, {a1, a2, ar});
      end
      if (o == lat) begin
        check("rsp_status", rsp_status, exp_st);
        check("rsp_cycles", rsp_cycles, r_len);
        check("busy_resp", busy, 1);
      end
      if (o == lat + 1) begin
        check("cmd_ready_back", cmd_ready, 1);
        check("busy_idle", busy, 0);
        check("rsp_status_hold", rsp_status, exp_st);
        check("dims_hold", {eng_dim_m, eng_dim_n}, {m, n});
      end
    end
    if (int'(op) < NOPS) eng_stuck[op] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] op;
    logic [3:0] m, n;
    int dly, mode;
    bit stuck;
    for (int k = 0; k < NOPS; k++) begin eng_dly[k] = 1; eng_stuck[k] = 1'b0; end
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_m = '0; cmd_n = '0;
    cmd_addr1 = '0; cmd_addr2 = '0; cmd_addr_res = '0;
    eng_rd_en = '0; eng_wr_en = '0; eng_rd_addr = '0; eng_wr_addr = '0;
    eng_wr_data = '0; bram_rd_data = '0;
    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_start", eng_start, 0);
    check("rst_rsp", {rsp_valid, rsp_status, rsp_cycles}, 0);
    check("rst_dims", {eng_dim_m, eng_dim_n, eng_addr_op1, eng_addr_op2, eng_addr_res}, 0);
    check_mux(-1);
    rst = 1'b0;
    tick();

    run_cmd(2'd2, 4'd3, 4'd3, 10'd0, 10'd16, 10'd32, 300, 1'b0);   // long convolution-style run
    run_cmd(2'd3, 4'd2, 4'd2, 10'd1, 10'd2, 10'd3, 5, 1'b0);       // op beyond NUM_OPS
    run_cmd(2'd0, 4'd0, 4'd3, 10'd4, 10'd5, 10'd6, 5, 1'b0);       // zero rows
    run_cmd(2'd1, 4'd3, 4'd6, 10'd7, 10'd8, 10'd9, 5, 1'b0);       // cols over max
    run_cmd(2'd0, 4'd5, 4'd5, 10'd10, 10'd11, 10'd12, 1, 1'b0);    // max dims, fastest done
    iso_mode = 1'b1;
    run_cmd(2'd1, 4'd2, 4'd4, 10'h100, 10'h120, 10'h140, 12, 1'b0);
    iso_mode = 1'b0;
    run_cmd(2'd0, 4'd1, 4'd1, 10'd20, 10'd21, 10'd22, 0, 1'b0);    // never done: timeout
    run_cmd(2'd1, 4'd2, 4'd2, 10'd23, 10'd24, 10'd25, 4, 1'b1);    // done stuck high
    run_cmd(2'd2, 4'd1, 4'd5, 10'd26, 10'd27, 10'd28, TMO - 1, 1'b0);

    // Reset in the middle of a run.
    eng_dly[1] = 0;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_m = 4'd2; cmd_n = 4'd2;
    tick();
    cmd_valid = 1'b0;
    repeat (10) tick();
    check("mid_run_start", eng_start, 3'b010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_run_start", eng_start, 0);
    check("rst_run_busy", busy, 0);
    check("rst_run_rsp", rsp_valid, 0);
    check_mux(-1);
    tick();
    check("rst_run_ready", cmd_ready, 1);
    check("rst_run_rsp2", rsp_valid, 0);
    check("rst_run_status", {rsp_status, rsp_cycles}, 0);
    run_cmd(2'd1, 4'd3, 4'd2, 10'd30, 10'd31, 10'd32, 3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, NOPS - 1));
      m  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, MAXD));
      n  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, MAXD));
      mode  = $urandom_range(0, 9);
      stuck = (mode == 1);
      dly   = (mode == 0) ? 0 : $urandom_range(1, 30);
      run_cmd(op, m, n, AW'($urandom), AW'($urandom), AW'($urandom), dly, stuck);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
